light_sequencer: RTL and testbench

Phase sequencer between the lane selector and the intersection light drivers. Takes the per-cycle lane choice (`laneRequest`, same WWSSEENN bit order as `laneOutput`) and the traffic mode (`currentState`). Turns them into a legal light sequence: GREEN → YELLOW → ALL_RED → next GREEN. Enforces minimum and maximum green times, pedestrian walk phases and emergency preemption.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 24 ++
 rtl/light_sequencer.sv | 143 ++++++++++++++
 tb/tb_light_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light path: mode codes, phase
// encoding, lane bit positions and direction helpers.
package traffic_pkg;

  localparam logic [1:0] MODE_NIGHT = 2'b00;
  localparam logic [1:0] MODE_DAY   = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10,
    PH_WALK    = 2'b11
  } phase_e;

  // LSB of each direction's two-lane field (WWSSEENN order)
  localparam int LANE_N = 0;
  localparam int LANE_E = 2;
  localparam int LANE_S = 4;
  localparam int LANE_W = 6;

  function automatic logic [7:0] dir_mask(input logic [1:0] d);
    logic [7:0] m;
    case (d)
      2'd0:    m = 8'b11 << LANE_N;
      2'd1:    m = 8'b11 << LANE_E;
      2'd2:    m = 8'b11 << LANE_S;
      default: m = 8'b11 << LANE_W;
    endcase
    return m;
  endfunction

  // Lowest-numbered direction with any lane granted; 0 when nothing granted.
  function automatic logic [1:0] lowest_dir(input logic [7:0] g);
    logic [1:0] d;
    d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (g[2*i +: 2] != 2'b00) d = 2'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: synchronous clear, increments otherwise,
// saturates at 255.
module phase_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (r_count != 8'hFF) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/light_sequencer.sv
// Phase sequencer: turns the per-cycle lane choice and traffic mode into a
// legal GREEN -> YELLOW -> ALL_RED sequence with walk and preemption.
module light_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 12,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] laneRequest,
  input  logic [1:0] currentState,
  input  logic [1:0] emgDir,
  output logic [7:0] green,
  output logic [7:0] yellow,
  output logic [7:0] red,
  output logic       walk,
  output logic [1:0] phase
);

  phase_e     r_phase;
  logic [7:0] r_grant;
  logic [7:0] r_next_grant;
  logic       r_ped_pending;
  logic [7:0] r_green;
  logic [7:0] r_yellow;
  logic [7:0] r_red;
  logic       r_walk;

  phase_e     w_phase_nx;
  logic [7:0] w_grant_nx;
  logic [7:0] w_next_grant_nx;
  logic [7:0] w_green_nx;
  logic [7:0] w_yellow_nx;
  logic [7:0] w_timer;
  logic [8:0] w_elapsed;
  logic [8:0] w_max_green;
  logic [7:0] w_emg_mask;
  logic       w_emg;
  logic       w_lane_switch;
  logic       w_timer_clr;

  phase_timer u_timer (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clear (w_timer_clr),
    .o_count (w_timer)
  );

  // Cycles spent in the current phase, counting the present one.
  assign w_elapsed     = {1'b0, w_timer} + 9'd1;
  assign w_max_green   = (currentState == MODE_NIGHT) ? 9'(2 * MAX_GREEN) : 9'(MAX_GREEN);
  assign w_emg         = (currentState == MODE_EMG);
  assign w_emg_mask    = dir_mask(emgDir);
  assign w_lane_switch = (laneRequest != 8'd0) && ((laneRequest & r_grant) == 8'd0);
  assign w_timer_clr   = (w_phase_nx != r_phase);

  always_comb begin
    w_phase_nx      = r_phase;
    w_grant_nx      = r_grant;
    w_next_grant_nx = r_next_grant;
    case (r_phase)
      PH_ALL_RED: begin
        if (w_elapsed >= 9'(ALLRED_TIME)) begin
          if (w_emg) begin
            w_phase_nx = PH_GREEN;
            w_grant_nx = w_emg_mask;
          end else if (r_ped_pending) begin
            w_phase_nx = PH_WALK;
          end else if (r_next_grant != 8'd0) begin
            w_phase_nx      = PH_GREEN;
            w_grant_nx      = r_next_grant;
            w_next_grant_nx = 8'd0;
          end else if (laneRequest != 8'd0) begin
            w_phase_nx = PH_GREEN;
            w_grant_nx = laneRequest;
          end
        end
      end
      PH_GREEN: begin
        // An emergency already holding its own direction never maxes out.
        if (w_emg) begin
          if (r_grant != w_emg_mask) begin
            w_phase_nx      = PH_YELLOW;
            w_next_grant_nx = 8'd0;
          end
        end else if ((w_elapsed >= 9'(MIN_GREEN)) && (r_ped_pending || w_lane_switch)) begin
          w_phase_nx      = PH_YELLOW;
          w_next_grant_nx = r_ped_pending ? 8'd0 : laneRequest;
        end else if (w_elapsed == w_max_green) begin
          w_phase_nx      = PH_YELLOW;
          w_next_grant_nx = dir_mask(lowest_dir(r_grant) + 2'd1);
        end
      end
      PH_YELLOW: begin
        if (w_elapsed >= 9'(YELLOW_TIME)) w_phase_nx = PH_ALL_RED;
      end
      PH_WALK: begin
        if (w_emg || (w_elapsed >= 9'(WALK_TIME))) w_phase_nx = PH_ALL_RED;
      end
      default: w_phase_nx = PH_ALL_RED;
    endcase

    w_green_nx  = (w_phase_nx == PH_GREEN)  ? w_grant_nx : 8'd0;
    w_yellow_nx = (w_phase_nx == PH_YELLOW) ? w_grant_nx : 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase       <= PH_ALL_RED;
      r_grant       <= 8'd0;
      r_next_grant  <= 8'd0;
      r_ped_pending <= 1'b0;
      r_green       <= 8'd0;
      r_yellow      <= 8'd0;
      r_red         <= 8'hFF;
      r_walk        <= 1'b0;
    end else begin
      r_phase      <= w_phase_nx;
      r_grant      <= w_grant_nx;
      r_next_grant <= w_next_grant_nx;
      if ((w_phase_nx == PH_WALK) && (r_phase != PH_WALK)) begin
        r_ped_pending <= 1'b0;
      end else if (currentState == MODE_PED) begin
        r_ped_pending <= 1'b1;
      end
      r_green  <= w_green_nx;
      r_yellow <= w_yellow_nx;
      r_red    <= ~(w_green_nx | w_yellow_nx);
      r_walk   <= (w_phase_nx == PH_WALK);
    end
  end

  assign green  = r_green;
  assign yellow = r_yellow;
  assign red    = r_red;
  assign walk   = r_walk;
  assign phase  = r_phase;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: expected per-cycle light traces are queued when
// each scenario starts and popped against the lamps one cycle at a time.
module tb_light_sequencer;

  localparam int W = 27;
  localparam logic [1:0] AR = 2'b00;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] YE = 2'b10;
  localparam logic [1:0] WK = 2'b11;
  localparam logic [1:0] NIGHT = 2'b00;
  localparam logic [1:0] DAY   = 2'b01;
  localparam logic [1:0] PED   = 2'b10;
  localparam logic [1:0] EMG   = 2'b11;

  logic       clk;
  logic       rst;
  logic [7:0] laneRequest;
  logic [1:0] currentState;
  logic [1:0] emgDir;
  logic [7:0] green;
  logic [7:0] yellow;
  logic [7:0] red;
  logic       walk;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  light_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .laneRequest  (laneRequest),
    .currentState (currentState),
    .emgDir       (emgDir),
    .green        (green),
    .yellow       (yellow),
    .red          (red),
    .walk         (walk),
    .phase        (phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

  function automatic logic [W-1:0] pk(input logic [1:0] ph, input logic [7:0] g,
                                      input logic [7:0] y, input logic w);
    return {ph, g, y, ~(g | y), w};
  endfunction

  function automatic logic [W-1:0] observed();
    return {phase, green, yellow, red, walk};
  endfunction

  // driver tasks
  task automatic push_n(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic start(input logic [1:0] mode, input logic [7:0] lane, input logic [1:0] dir);
    rst          = 1'b0;
    currentState = mode;
    laneRequest  = lane;
    emgDir       = dir;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      laneRequest  = 8'($urandom_range(0, 255));
      currentState = 2'($urandom_range(0, 3));
      emgDir       = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== pk(AR, 8'h00, 8'h00, 1'b0)) begin
        errors++;
        $display("FAIL reset i%0d got %h exp %h", i, got, pk(AR, 8'h00, 8'h00, 1'b0));
      end
    end
    checks++;
    if (red !== 8'hFF) begin
      errors++;
      $display("FAIL reset_red got %h exp ff", red);
    end
  endtask

  task automatic test_reset_mid();
    start(DAY, 8'h02, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (green !== 8'h02) begin
      errors++;
      $display("FAIL reset_mid_pre got green %h exp 02", green);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== pk(AR, 8'h00, 8'h00, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid got %h exp %h", observed(), pk(AR, 8'h00, 8'h00, 1'b0));
    end
    @(posedge clk);
    #1;
    checks++;
    if (yellow !== 8'h00 || phase !== AR) begin
      errors++;
      $display("FAIL reset_mid_noyellow got yellow %h phase %h exp 00 0", yellow, phase);
    end
  endtask

  task automatic test_demand_switch();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    start(DAY, 8'h02, 2'd0);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h02, 8'h00, 1'b0), 4);
    push_n(pk(YE, 8'h00, 8'h02, 1'b0), 2);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h40, 8'h00, 1'b0), 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL demand c%0d got %h exp %h", c, got, exp);
      end
      if (c == 2) laneRequest = 8'h40;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_max_out(input logic [1:0] mode, input int max_len, input logic full);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    start(mode, 8'h0C, 2'd0);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h0C, 8'h00, 1'b0), max_len);
    push_n(pk(YE, 8'h00, 8'h0C, 1'b0), 2);
    if (full) begin
      push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
      push_n(pk(GR, 8'h30, 8'h00, 1'b0), 4);
      push_n(pk(YE, 8'h00, 8'h30, 1'b0), 2);
      push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
      push_n(pk(GR, 8'h0C, 8'h00, 1'b0), 2);
    end
    for (int c = 0; exp_q.size() > 0; c++) begin
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL maxout m%0d c%0d got %h exp %h", mode, c, got, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_pedestrian();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    start(DAY, 8'h02, 2'd0);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h02, 8'h00, 1'b0), 4);
    push_n(pk(YE, 8'h00, 8'h02, 1'b0), 2);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(WK, 8'h00, 8'h00, 1'b1), 6);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h02, 8'h00, 1'b0), 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ped c%0d got %h exp %h", c, got, exp);
      end
      currentState = (c == 1) ? PED : DAY;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_emergency();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    start(DAY, 8'h02, 2'd0);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h02, 8'h00, 1'b0), 2);
    push_n(pk(YE, 8'h00, 8'h02, 1'b0), 2);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h30, 8'h00, 1'b0), 20);
    for (int c = 0; exp_q.size() > 0; c++) begin
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL emg c%0d got %h exp %h", c, got, exp);
      end
      if (c == 2) begin
        currentState = EMG;
        emgDir       = 2'd2;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_emergency_walk();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    start(DAY, 8'h02, 2'd0);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h02, 8'h00, 1'b0), 4);
    push_n(pk(YE, 8'h00, 8'h02, 1'b0), 2);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(WK, 8'h00, 8'h00, 1'b1), 3);
    push_n(pk(AR, 8'h00, 8'h00, 1'b0), 1);
    push_n(pk(GR, 8'h0C, 8'h00, 1'b0), 3);
    for (int c = 0; exp_q.size() > 0; c++) begin
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL emg_walk c%0d got %h exp %h", c, got, exp);
      end
      if (c == 1) currentState = PED;
      else if (c >= 10) begin
        currentState = EMG;
        emgDir       = 2'd1;
      end else currentState = DAY;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst          = 1'b0;
    laneRequest  = 8'd0;
    currentState = DAY;
    emgDir       = 2'd0;
    test_reset();
    test_reset_mid();
    test_demand_switch();
    test_max_out(DAY, 12, 1'b1);
    test_max_out(NIGHT, 24, 1'b0);
    test_pedestrian();
    test_emergency();
    test_emergency_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
